srl_fifo_arbiter: RTL and testbench
===================================

SRL_FIFO_ARBITER -- requirements
Module: srl_fifo_arbiter

Interface
REQ-001 Parameter: width, 128, data bits per beat for every port and the shared FIFO.
REQ-002 Parameter: nport, 4, number of requesters; legal range 2..16.
REQ-003 Parameter: l2nport, 2, ceil(log2(nport)); sets the pointer and owner register width.
REQ-004 Port: CLK  in  1  clock; all state changes on rising edge.
REQ-005 Port: RST_N  in  1  reset, synchronous, active-low.
REQ-006 Port: CLR  in  1  synchronous clear; same effect as reset.
REQ-007 Port: REQ  in  nport  per-requester beat-valid.
REQ-008 Port: EOP  in  nport  per-requester end-of-packet flag, qualified by REQ.
REQ-009 Port: D_IN  in  nport*width  requester data, port k at bits [k*width +: width].
REQ-010 Port: GNT  out  nport  one-hot or zero; port k's beat is accepted in any cycle with REQ[k] && GNT[k].
REQ-011 Port: FIFO_FULL_N  in  1  FULL_N from the shared SRL FIFO.
REQ-012 Port: FIFO_ENQ  out  1  ENQ to the shared FIFO.
REQ-013 Port: FIFO_D  out  width  D_IN to the shared FIFO.
REQ-014 Port: BEATS  out  32  registered count of accepted beats; wraps modulo 2^32.

Function
REQ-015 GNT, FIFO_ENQ and FIFO_D shall be combinational from REQ, FIFO_FULL_N and registered state, giving zero-cycle latency from request to enqueue.
REQ-016 If FIFO_FULL_N=0, GNT shall be all-zero, FIFO_ENQ shall be 0, and no state shall change.
REQ-017 In state IDLE, GNT shall select the first k with REQ[k]=1, searching from ptr upward modulo nport.
REQ-018 FIFO_ENQ shall be the OR of REQ&GNT, and FIFO_D shall be D_IN slice of the granted port; FIFO_D shall be 0 when nothing is granted.
REQ-019 On an accepted beat from port k in IDLE with EOP[k]=1, ptr shall become (k+1) mod nport and the state shall stay IDLE.
REQ-020 The behaviour of an accepted beat with EOP[k]=0 depends on lock mode (REQ-028/029).
REQ-021 In state LOCK, GNT shall be asserted only to owner, and only while REQ[owner]=1; other requesters are blocked.
REQ-022 In state LOCK, an accepted beat with EOP[owner]=1 shall move the state to IDLE and set ptr to (owner+1) mod nport.
REQ-023 BEATS shall increment by 1 on every cycle with FIFO_ENQ=1.
REQ-024 Fairness: any port holding REQ=1 in IDLE mode shall be granted within nport accepted beats, when running without lock.

Reset
REQ-025 On RST_N=0 or CLR=1 at a clock edge, the following shall load: ptr=0, state=IDLE, owner=0, BEATS=0.
REQ-026 Reset and CLR shall take priority over a same-cycle accepted beat; that beat shall not be counted and shall not alter ptr.
REQ-027 A reset during LOCK shall abandon the packet; the arbiter shall re-arbitrate from port 0.

Configuration
REQ-028 With macro ARB_PKT_LOCK_EN defined, an accepted beat with EOP[k]=0 in IDLE shall enter LOCK with owner=k, holding ptr unchanged.
REQ-029 Without ARB_PKT_LOCK_EN, EOP shall be ignored; every accepted beat shall behave as REQ-019, giving per-beat round-robin, and LOCK shall be unreachable.

Structure
REQ-030 A shared package shall hold the state enumeration {IDLE, LOCK} and the BEATS width constant (32).
REQ-031 The round-robin priority search shall be one sub-module, rr_pick: inputs REQ vector and ptr; outputs a one-hot grant. It shall be purely combinational.
REQ-032 The top level shall instantiate rr_pick once and own ptr, state, owner and BEATS.

Verification
REQ-033 Test 1: after reset, REQ=4'b1111, FULL_N=1, all EOP=1. Required response: GNT sequence 0001, 0010, 0100, 1000, 0001, and BEATS=4 after 4 cycles.
REQ-034 Test 2: REQ=4'b1010, FULL_N=0 for 3 cycles, then 1. Required response: GNT=0 and BEATS=0 during the stall; GNT=0010 on the first cycle after the stall.
REQ-035 Test 3 (ARB_PKT_LOCK_EN defined): port 2 sends a 3-beat packet with EOP on beat 3 while REQ=1111. Required response: GNT=0100 for 3 accepted beats, then 1000.
REQ-036 Test 4: same stimulus as test 3 without ARB_PKT_LOCK_EN. Required response: GNT rotates 0100, 1000, 0001.
REQ-037 Test 5: RST_N=0 mid-packet during LOCK with owner=3 and REQ=1111. Required response: next cycle IDLE with GNT=0001, and BEATS=0.
REQ-038 Test 6: preload BEATS at 32'hFFFFFFFF via 2^32-1 forced beats, then accept one beat. Required response: BEATS=0.

Source files
------------

// File: rtl/srl_fifo_arbiter_pkg.sv
// Shared types and constants for the SRL FIFO front-end arbiter.
package srl_fifo_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int BEATS_W = 32;

endpackage

// File: rtl/srl_fifo_arbiter_rr_pick.sv
// Round-robin priority search: one-hot grant to the first requester found
// from ptr upward, wrapping modulo nport. Purely combinational.
module rr_pick #(
    parameter int nport   = 4,
    parameter int l2nport = 2
) (
    input  logic [nport-1:0]   req,
    input  logic [l2nport-1:0] ptr,
    output logic [nport-1:0]   gnt
);

    logic [2*nport-1:0] dbl;
    logic [2*nport-1:0] shifted;
    logic [nport-1:0]   rot;
    logic [nport-1:0]   first;
    logic [2*nport-1:0] back;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    assign dbl     = {req, req};
    assign shifted = dbl >> ptr;
    assign rot     = shifted[nport-1:0];
    assign first   = rot & (~rot + 1'b1);
    assign back    = {first, first} << ptr;
    assign gnt     = back[2*nport-1:nport];

endmodule

// File: rtl/srl_fifo_arbiter.sv
// N-port arbiter in front of a shared SRL FIFO. Zero-latency grant/enqueue,
// round-robin between packets. Optional packet lock: define ARB_PKT_LOCK_EN
// to hold the grant on one requester until its EOP beat.
module srl_fifo_arbiter
    import srl_fifo_arbiter_pkg::*;
#(
    parameter int width   = 128,
    parameter int nport   = 4,
    parameter int l2nport = 2
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     CLR,
    input  logic [nport-1:0]         REQ,
    input  logic [nport-1:0]         EOP,
    input  logic [nport*width-1:0]   D_IN,
    output logic [nport-1:0]         GNT,
    input  logic                     FIFO_FULL_N,
    output logic                     FIFO_ENQ,
    output logic [width-1:0]         FIFO_D,
    output logic [BEATS_W-1:0]       BEATS
);

    arb_state_t          state_q, state_d;
    logic [l2nport-1:0]  ptr_q, ptr_d;
    logic [l2nport-1:0]  owner_q, owner_d;
    logic [BEATS_W-1:0]  beats_q;
    logic [nport-1:0]    pick_gnt;
    logic [nport-1:0]    gnt;
    logic [l2nport-1:0]  gidx;
    logic                accept;

    function automatic logic [l2nport-1:0] next_ptr(input logic [l2nport-1:0] k);
        return (k == l2nport'(nport - 1)) ? '0 : k + 1'b1;
    endfunction

    rr_pick #(
        .nport   (nport),
        .l2nport (l2nport)
    ) u_rr_pick (
        .req (REQ),
        .ptr (ptr_q),
        .gnt (pick_gnt)
    );

    // Grant: nothing while the FIFO is full, owner only while locked.
    always_comb begin
        gnt = '0;
        if (FIFO_FULL_N) begin
            if (state_q == LOCK) begin
                gnt[owner_q] = REQ[owner_q];
            end else begin
                gnt = pick_gnt;
            end
        end
    end

    // Data mux and granted-port index; both zero when nothing is granted.
    always_comb begin
        FIFO_D = '0;
        gidx   = '0;
        for (int k = 0; k < nport; k++) begin
            if (gnt[k]) begin
                FIFO_D = FIFO_D | D_IN[k*width +: width];
                gidx   = gidx | l2nport'(k);
            end
        end
    end

    assign accept   = |(REQ & gnt);
    assign GNT      = gnt;
    assign FIFO_ENQ = accept;
    assign BEATS    = beats_q;

`ifndef ARB_PKT_LOCK_EN
    logic unused_eop;
    assign unused_eop = ^EOP;
`endif

    // Next state, pointer and owner on an accepted beat.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (accept) begin
            if (state_q == LOCK) begin
                if (EOP[owner_q]) begin
                    state_d = IDLE;
                    ptr_d   = next_ptr(owner_q);
                end
            end else begin
`ifdef ARB_PKT_LOCK_EN
                if (!EOP[gidx]) begin
                    state_d = LOCK;
                    owner_d = gidx;
                end else begin
                    ptr_d = next_ptr(gidx);
                end
`else
                ptr_d = next_ptr(gidx);
`endif
            end
        end
    end

    // State registers; reset and clear win over a same-cycle beat.
    always_ff @(posedge CLK) begin
        if (!RST_N || CLR) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            beats_q <= '0;
        end else if (accept) begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            beats_q <= beats_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_srl_fifo_arbiter.sv
// Self-checking bench for srl_fifo_arbiter: directed literal scenarios plus
// randomized traffic checked every cycle against a behavioural model.
// Build with or without ARB_PKT_LOCK_EN; expectations follow the macro.
module tb_srl_fifo_arbiter;

    localparam int W  = 128;
    localparam int NP = 4;
`ifdef ARB_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clr = 1'b0;
    logic [NP-1:0]   req = '0;
    logic [NP-1:0]   eop = '0;
    logic [NP*W-1:0] d_in = '0;
    logic [NP-1:0]   gnt;
    logic            full_n = 1'b1;
    logic            enq;
    logic [W-1:0]    fifo_d;
    logic [31:0]     beats;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // model state
    int          m_ptr = 0;
    bit          m_locked = 1'b0;
    int          m_owner = 0;
    logic [31:0] m_beats = '0;

    srl_fifo_arbiter #(.width(W), .nport(NP), .l2nport(2)) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .CLR         (clr),
        .REQ         (req),
        .EOP         (eop),
        .D_IN        (d_in),
        .GNT         (gnt),
        .FIFO_FULL_N (full_n),
        .FIFO_ENQ    (enq),
        .FIFO_D      (fifo_d),
        .BEATS       (beats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NP-1:0] exp_gnt();
        logic [NP-1:0] g;
        g = '0;
        if (!full_n) return g;
        if (m_locked) begin
            if (req[m_owner]) g[m_owner] = 1'b1;
            return g;
        end
        for (int i = 0; i < NP; i++) begin
            if (req[(m_ptr + i) % NP]) begin
                g[(m_ptr + i) % NP] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic logic [W-1:0] exp_data(input logic [NP-1:0] g);
        for (int k = 0; k < NP; k++)
            if (g[k]) return d_in[k*W +: W];
        return '0;
    endfunction

    // Model update at each active edge from the inputs held across it.
    always @(posedge clk) begin
        logic [NP-1:0] g;
        int k;
        g = exp_gnt();
        k = 0;
        for (int i = 0; i < NP; i++) if (g[i]) k = i;
        if (!rst_n || clr) begin
            m_ptr = 0; m_locked = 1'b0; m_owner = 0; m_beats = '0;
        end else if (g != '0) begin
            m_beats = m_beats + 32'd1;
            if (m_locked) begin
                if (eop[k]) begin
                    m_locked = 1'b0;
                    m_ptr = (k + 1) % NP;
                end
            end else if (LOCK_EN && !eop[k]) begin
                m_locked = 1'b1;
                m_owner = k;
            end else begin
                m_ptr = (k + 1) % NP;
            end
        end
    end

    // Compare DUT outputs with the model mid-cycle.
    always @(negedge clk) begin
        logic [NP-1:0] g;
        if (chk_en) begin
            g = exp_gnt();
            chk("gnt",    W'(gnt),   W'(g));
            chk("enq",    W'(enq),   W'(|g));
            chk("fifo_d", fifo_d,    exp_data(g));
            chk("beats",  W'(beats), W'(m_beats));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clr = 1'b0; req = '0; eop = '0; full_n = 1'b1;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic rand_data();
        for (int w = 0; w < NP*W/32; w++) d_in[w*32 +: 32] = $urandom;
    endtask

    initial begin
        logic [NP-1:0] seq1 [5];
        seq1[0] = 4'b0001; seq1[1] = 4'b0010; seq1[2] = 4'b0100;
        seq1[3] = 4'b1000; seq1[4] = 4'b0001;
        rand_data();

        // round robin with EOP on every beat
        do_reset();
        req = 4'b1111; eop = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t1_gnt", W'(gnt), W'(seq1[i]));
            if (i == 4) chk("t1_beats", W'(beats), W'(32'd4));
            cyc();
        end

        // FIFO full stall
        do_reset();
        req = 4'b1010; eop = 4'b1111; full_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_stall_gnt", W'(gnt), W'(4'b0000));
            chk("t2_stall_beats", W'(beats), W'(32'd0));
            cyc();
        end
        full_n = 1'b1;
        #1;
        chk("t2_resume_gnt", W'(gnt), W'(4'b0010));
        cyc();

        // 3-beat packet from port 2
        do_reset();
        req = 4'b1111; eop = 4'b1111;
        cyc(); cyc();
        eop = 4'b1011;
        #1; chk("t3_beat1", W'(gnt), W'(4'b0100));
        cyc();
        #1; chk("t3_beat2", W'(gnt), LOCK_EN ? W'(4'b0100) : W'(4'b1000));
        cyc();
        eop = 4'b1111;
        #1; chk("t3_beat3", W'(gnt), LOCK_EN ? W'(4'b0100) : W'(4'b0001));
        cyc();
        #1; chk("t3_after", W'(gnt), LOCK_EN ? W'(4'b1000) : W'(4'b0010));
        cyc();

        // reset in the middle of a packet owned by port 3
        do_reset();
        req = 4'b1111; eop = 4'b1111;
        cyc(); cyc(); cyc();
        eop = 4'b0111;
        #1; chk("t5_first", W'(gnt), W'(4'b1000));
        cyc();
        #1; chk("t5_mid", W'(gnt), LOCK_EN ? W'(4'b1000) : W'(4'b0001));
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
        chk("t5_gnt", W'(gnt), W'(4'b0001));
        chk("t5_beats", W'(beats), W'(32'd0));
        cyc();

        // beat counter wrap
        do_reset();
        req = '0; eop = 4'b1111;
        cyc();
        force dut.beats_q = 32'hFFFF_FFFF;
        #1;
        release dut.beats_q;
        m_beats = 32'hFFFF_FFFF;
        #1;
        chk("t6_preload", W'(beats), W'(32'hFFFF_FFFF));
        req = 4'b0001;
        cyc();
        req = '0;
        #1;
        chk("t6_wrap", W'(beats), W'(32'd0));
        cyc();

        // randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            req    = NP'($urandom);
            eop    = NP'($urandom | $urandom);
            full_n = ($urandom_range(0, 7) != 0);
            clr    = ($urandom_range(0, 99) == 0);
            rst_n  = ($urandom_range(0, 199) != 0);
            rand_data();
            cyc();
        end
        rst_n = 1'b1; clr = 1'b0; req = '0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
